// File: rtl/key_conditioner.sv
// Push-button front end: synchronise, debounce and auto-repeat two keys
// into clean one-cycle command pulses plus debounced held levels.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic Key1,
  input  logic Key2,
  output logic Key1_pulse,
  output logic Key2_pulse,
  output logic Key1_level,
  output logic Key2_level
);

  // Repeat intervals below 2 would emit back-to-back pulses on one key.
  localparam int DEB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int RD  = (REPEAT_DELAY < 2) ? 2 : REPEAT_DELAY;
  localparam int RR  = (REPEAT_RATE < 2) ? 2 : REPEAT_RATE;
  localparam bit RPT_EN = (REPEAT_RATE != 0);
  localparam int M1 = (DEB > RD) ? DEB : RD;
  localparam int MX = (M1 > RR) ? M1 : RR;
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] w_s;
  logic [1:0] w_cand;
  logic [1:0] w_lvl_n;
  logic [1:0] w_pulse_n;
  logic [1:0] r_pulse;
  logic [1:0] r_level;
  logic       w_both;

  assign w_raw = {Key2, Key1};

  // Raw polarity is kept through the synchroniser, so reset loads the
  // released raw level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_meta <= {2{KEY_ACTIVE_LOW}};
      r_sync <= {2{KEY_ACTIVE_LOW}};
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  assign w_s    = r_sync ^ {2{KEY_ACTIVE_LOW}};
  assign w_both = r_level[0] & r_level[1];

  for (genvar g = 0; g < 2; g++) begin : g_key
    state_t          r_state;
    state_t          w_state_n;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_n;
    logic [CW-1:0]   r_rpt;
    logic [CW-1:0]   w_rpt_n;
    logic [CW-1:0]   w_tgt;
    logic            r_rep;
    logic            w_rep_n;
    logic            w_press_c;
    logic            w_rpt_c;

    assign w_tgt = r_rep ? CW'(RR) : CW'(RD);

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_rpt   <= '0;
        r_rep   <= 1'b0;
      end else begin
        r_state <= w_state_n;
        r_cnt   <= w_cnt_n;
        r_rpt   <= w_rpt_n;
        r_rep   <= w_rep_n;
      end
    end

    always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_rpt_n   = r_rpt;
      w_rep_n   = r_rep;
      w_press_c = 1'b0;
      w_rpt_c   = 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_s[g]) begin
            w_state_n = DEB_PRESS;
            w_cnt_n   = CW'(1);
          end
        end
        DEB_PRESS: begin
          if (!w_s[g]) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
          end else if (r_cnt == CW'(DEB)) begin
            w_state_n = HELD;
            w_cnt_n   = '0;
            w_rpt_n   = '0;
            w_rep_n   = 1'b0;
            w_press_c = 1'b1;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!w_s[g]) begin
            w_state_n = DEB_RELEASE;
            w_cnt_n   = CW'(1);
            w_rpt_n   = '0;
            w_rep_n   = 1'b0;
          end else if (RPT_EN && !w_both) begin
            // rpt restarts after each pulse; r_rep selects the target
            w_rpt_n = r_rpt + CW'(1);
            if (w_rpt_n == w_tgt) begin
              w_rpt_c = 1'b1;
              w_rpt_n = '0;
              w_rep_n = 1'b1;
            end
          end
        end
        DEB_RELEASE: begin
          if (w_s[g]) begin
            w_state_n = HELD;
            w_cnt_n   = '0;
            w_rpt_n   = '0;
            w_rep_n   = 1'b0;
          end else if (r_cnt == CW'(DEB)) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
          w_rpt_n   = '0;
          w_rep_n   = 1'b0;
        end
      endcase
    end

    assign w_cand[g]  = w_press_c | w_rpt_c;
    assign w_lvl_n[g] = (w_state_n == HELD) ||
                        (w_state_n == DEB_RELEASE);
  end

  // Contradictory commands in the same cycle are dropped together.
  assign w_pulse_n = (&w_cand) ? 2'b00 : w_cand;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pulse <= 2'b00;
      r_level <= 2'b00;
    end else begin
      r_pulse <= w_pulse_n;
      r_level <= w_lvl_n;
    end
  end

  assign Key1_pulse = r_pulse[0];
  assign Key2_pulse = r_pulse[1];
  assign Key1_level = r_level[0];
  assign Key2_level = r_level[1];

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: directed key scenarios push
// expected pulse cycles, a monitor pops them as pulses appear.
module tb_key_conditioner;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Key1 = 1'b1;
  logic Key2 = 1'b1;
  logic Key1_pulse;
  logic Key2_pulse;
  logic Key1_level;
  logic Key2_level;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Key1(Key1),
    .Key2(Key2),
    .Key1_pulse(Key1_pulse),
    .Key2_pulse(Key2_pulse),
    .Key1_level(Key1_level),
    .Key2_level(Key2_level)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] k;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int base = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [1:0] k);
    exp_t e;
    e.c = base + c;
    e.k = k;
    q.push_back(e);
  endtask

  // Returns at the negedge following edge base+k.
  task automatic tick_to(input int k);
    while (cyc < base + k) @(negedge CLK);
  endtask

  task automatic new_phase();
    @(negedge CLK);
    base = cyc + 1;
  endtask

  task automatic drain(input string nm);
    repeat (20) @(negedge CLK);
    chk(nm, q.size(), 0);
    q.delete();
  endtask

  // Monitor: every observed pulse must match the queue head.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (Key1_pulse || Key2_pulse) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_pulse: got k=%b want none (cyc %0d)",
                 {Key2_pulse, Key1_pulse}, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("pulse_key", {Key2_pulse, Key1_pulse}, e.k);
      end
    end
  end

  initial begin
    // 1: reset then idle
    repeat (3) @(negedge CLK);
    chk("rst_outputs",
        {Key2_pulse, Key1_pulse, Key2_level, Key1_level}, 0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge CLK);
      chk("idle_levels", {Key2_level, Key1_level}, 0);
    end
    drain("p1_queue");

    // 2: clean press on Key2
    new_phase();
    tick_to(9);
    Key2 = 1'b0;
    expect_pulse(16, 2'b10);
    tick_to(15);
    chk("p2_lvl_before", Key2_level, 0);
    tick_to(16);
    chk("p2_lvl_rise", Key2_level, 1);
    tick_to(19);
    Key2 = 1'b1;
    tick_to(25);
    chk("p2_lvl_hold", Key2_level, 1);
    tick_to(26);
    chk("p2_lvl_fall", Key2_level, 0);
    chk("p2_key1_lvl", Key1_level, 0);
    drain("p2_queue");

    // 3: bounce on Key1, then steady press
    new_phase();
    for (int i = 0; i < 16; i++) begin
      tick_to(2 * i - 1);
      Key1 = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    tick_to(31);
    chk("p3_bounce_lvl", Key1_level, 0);
    Key1 = 1'b0;
    expect_pulse(38, 2'b01);
    tick_to(37);
    chk("p3_lvl_before", Key1_level, 0);
    tick_to(38);
    chk("p3_lvl_rise", Key1_level, 1);
    tick_to(44);
    Key1 = 1'b1;
    drain("p3_queue");
    chk("p3_lvl_end", Key1_level, 0);

    // 4: auto-repeat on Key2
    new_phase();
    tick_to(-1);
    Key2 = 1'b0;
    expect_pulse(6, 2'b10);
    expect_pulse(26, 2'b10);
    expect_pulse(34, 2'b10);
    expect_pulse(42, 2'b10);
    expect_pulse(50, 2'b10);
    expect_pulse(58, 2'b10);
    tick_to(59);
    Key2 = 1'b1;
    tick_to(65);
    chk("p4_lvl_hold", Key2_level, 1);
    tick_to(66);
    chk("p4_lvl_fall", Key2_level, 0);
    drain("p4_queue");

    // 5: simultaneous press, then Key1 released
    new_phase();
    tick_to(-1);
    Key1 = 1'b0;
    Key2 = 1'b0;
    tick_to(30);
    chk("p5_both_lvl", {Key2_level, Key1_level}, 2'b11);
    tick_to(49);
    Key1 = 1'b1;
    expect_pulse(76, 2'b10);
    expect_pulse(84, 2'b10);
    tick_to(56);
    chk("p5_lvl1_fall", {Key2_level, Key1_level}, 2'b10);
    tick_to(85);
    Key2 = 1'b1;
    drain("p5_queue");

    // 6: reset while Key1 is held
    new_phase();
    tick_to(-1);
    Key1 = 1'b0;
    expect_pulse(6, 2'b01);
    tick_to(11);
    chk("p6_lvl_pre_rst", Key1_level, 1);
    RST = 1'b1;
    #1;
    chk("p6_async_clear",
        {Key2_pulse, Key1_pulse, Key2_level, Key1_level}, 0);
    tick_to(13);
    RST = 1'b0;
    expect_pulse(20, 2'b01);
    tick_to(19);
    chk("p6_lvl_redeb", Key1_level, 0);
    tick_to(30);
    Key1 = 1'b1;
    drain("p6_queue");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
